dmem_controller: RTL
====================

# dmem_controller

Arbitrating controller between the per-thread load/store requesters of all cores and the GPU's data memory channels. It maps `NUM_CONSUMERS` valid/ready requesters onto `NUM_CHANNELS` external memory channels. Each channel runs its own transaction state machine. Each consumer is served by at most one channel at a time. It sits between the cores' LSUs and the `data_mem_*` port bundle at the GPU top level.

## Interface
- `NUM_CONSUMERS`, default 32: number of requesters (cores × threads).
- `NUM_CHANNELS`, default 8: number of external data memory channels.
- `ADDR_WIDTH`, default `DATA_MEMORY_ADDRESS_WIDTH`: address width.
- `DATA_WIDTH`, default `DATA_WIDTH`: data width.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `consumer_read_valid` in [NUM_CONSUMERS]: read request.
- `consumer_read_address` in ADDR_WIDTH × NUM_CONSUMERS: read address.
- `consumer_read_ready` out [NUM_CONSUMERS]: read data valid; held until request drops.
- `consumer_read_data` out DATA_WIDTH × NUM_CONSUMERS: registered read data.
- `consumer_write_valid`, `consumer_write_address`, `consumer_write_data` in: write request, address and data.
- `consumer_write_ready` out [NUM_CONSUMERS]: write acknowledge.
- `mem_read_valid` out [NUM_CHANNELS]; `mem_read_address` out ADDR_WIDTH × NUM_CHANNELS; `mem_read_ready` in [NUM_CHANNELS]; `mem_read_data` in DATA_WIDTH × NUM_CHANNELS.
- `mem_write_valid` out [NUM_CHANNELS]; `mem_write_address` out; `mem_write_data` out; `mem_write_ready` in [NUM_CHANNELS].

## Operation
- Per-channel FSM states:
  - IDLE → READ_WAIT or WRITE_WAIT on grant.
  - READ_WAIT / WRITE_WAIT → RELEASE when the corresponding `mem_*_ready` is sampled high.
  - RELEASE → IDLE when the served consumer's valid for that operation is sampled low.
- Grant: in IDLE, a channel picks an eligible consumer.
  - Eligible means read or write valid is high, the consumer is not owned by any channel, and it is not granted this cycle by a lower-index channel.
  - The claim mask chains combinationally from channel 0 upward. Several channels may grant distinct consumers in the same cycle.
- Channel registers at grant: owner index, operation, address and write data. `mem_*_valid` is driven from registered state.
- If a consumer asserts both read and write valid, read wins. The write is served on a later grant.
- READ_WAIT completion:
  - Latch `mem_read_data` into `consumer_read_data[owner]`.
  - Set `consumer_read_ready[owner]`=1 and clear `mem_read_valid`.
- WRITE_WAIT completion: set `consumer_write_ready[owner]`=1 and clear `mem_write_valid`.
- RELEASE exit: the consumer's ready clears and ownership is freed. The channel can grant again in the following IDLE cycle.
- Requesters must hold valid, address and data stable from assertion until they see ready. Later changes are ignored.

## Timing
- Reset (asynchronous) forces:
  - all FSMs to IDLE;
  - all `mem_*_valid`, `consumer_*_ready`, addresses, write data and `consumer_read_data` to 0;
  - the RR pointer to 0.
- Reset mid-transaction abandons the transaction. `mem_*_valid` drops immediately (asynchronously).
- Latency with memory ready tied high:
  - consumer valid high in cycle 0;
  - `mem_*_valid` high after edge 1;
  - `consumer_*_ready` high after edge 2.
- Memory stall: `mem_*_valid` and address stay asserted and constant until ready is sampled. Each extra stall cycle adds one cycle of latency.
- Release: valid low sampled at edge k; ready low after edge k; channel IDLE after edge k; earliest re-grant at edge k+1.
- No consumer ever sees ready from two channels. No channel ever asserts read and write valid together.
- All consumers requesting and all channels busy: requests wait with no loss. Order follows the arbitration policy.

## Configuration
- `DMEM_CTRL_ROUND_ROBIN_EN` defined:
  - the search starts at a rotating pointer;
  - on any grant cycle the pointer advances to (highest granted consumer index + 1) mod NUM_CONSUMERS, wrapping at NUM_CONSUMERS-1 → 0.
- Undefined: fixed priority, lowest consumer index first, no pointer state.

## Test plan
- Single read, ready tied high:
  - consumer 3 reads addr 0x40, memory returns 0xDEADBEEF;
  - `mem_read_valid` rises after edge 1 on channel 0;
  - `consumer_read_ready[3]` and data 0xDEADBEEF appear after edge 2;
  - ready clears on the edge after valid drops.
- Write with 5-cycle `mem_write_ready` stall:
  - address and data are held for 5 cycles;
  - `consumer_write_ready` asserts 1 cycle after ready is sampled.
- Oversubscription with 8 channels:
  - all 32 consumers read at once; exactly 8 grants in the first cycle, with distinct consumers on distinct channels;
  - all 32 complete, each consumer acked exactly once.
- Arbitration policy:
  - with RR_EN, consumers 0 and 31 repeatedly requesting on a 1-channel config alternate;
  - without RR_EN, consumer 0 starves 31 while 0 keeps requesting.
- Reset asserted while a channel is in READ_WAIT:
  - all outputs go to 0 immediately;
  - after deassertion, a new request completes normally.
- Simultaneous read and write valid from consumer 5:
  - read is served first;
  - after release, write is served on the next grant.

Source files
------------

// File: rtl/dmem_controller.sv
`default_nettype none
// ============================================================================
// Module   : dmem_controller
// Purpose  : Arbitrates per-thread LSU requesters onto the GPU data-memory
//            channels, one transaction FSM per channel.
// Option   : DMEM_CTRL_ROUND_ROBIN_EN selects rotating-priority arbitration;
//            without it the lowest requesting consumer index wins.
// Revision : 1.0
// ============================================================================
module dmem_controller #(
    parameter int NUM_CONSUMERS = 32,
    parameter int NUM_CHANNELS  = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                                      clk,
    input  logic                                      reset,

    input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                  consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_WIDTH-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                  consumer_write_ready,

    output logic [NUM_CHANNELS-1:0]                   mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                   mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]                   mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]   mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                   mem_write_ready
);

    localparam int OWNER_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ_WAIT  = 2'd1,
        ST_WRITE_WAIT = 2'd2,
        ST_RELEASE    = 2'd3
    } state_t;

    state_t                 state_q [NUM_CHANNELS];
    state_t                 state_d [NUM_CHANNELS];
    logic [OWNER_W-1:0]     owner_q [NUM_CHANNELS];
    logic [OWNER_W-1:0]     owner_d [NUM_CHANNELS];
    logic [ADDR_WIDTH-1:0]  addr_q  [NUM_CHANNELS];
    logic [ADDR_WIDTH-1:0]  addr_d  [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]  wdata_q [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]  wdata_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] op_write_q, op_write_d;

    logic [NUM_CONSUMERS-1:0]                 rd_ready_q, rd_ready_d;
    logic [NUM_CONSUMERS-1:0]                 wr_ready_q, wr_ready_d;
    logic [NUM_CONSUMERS-1:0][DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [NUM_CONSUMERS-1:0]                 w_owned;

`ifdef DMEM_CTRL_ROUND_ROBIN_EN
    logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

    always_comb begin
        w_owned = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (state_q[ch] != ST_IDLE) begin
                w_owned[owner_q[ch]] = 1'b1;
            end
        end
    end

    // Channels are visited in index order so the claim mask carries each
    // lower channel's same-cycle grant into the search of the next one.
    always_comb begin
        logic [NUM_CONSUMERS-1:0] claim;
        logic                     found;
        int                       pick;
        int                       idx;
`ifdef DMEM_CTRL_ROUND_ROBIN_EN
        logic                     any_grant;
        int                       hi_grant;
        any_grant = 1'b0;
        hi_grant  = 0;
`endif
        claim      = w_owned;
        found      = 1'b0;
        pick       = 0;
        idx        = 0;
        rd_ready_d = rd_ready_q;
        wr_ready_d = wr_ready_q;
        rd_data_d  = rd_data_q;
        op_write_d = op_write_q;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            state_d[ch] = state_q[ch];
            owner_d[ch] = owner_q[ch];
            addr_d[ch]  = addr_q[ch];
            wdata_d[ch] = wdata_q[ch];
        end

        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state_q[ch])
                ST_IDLE: begin
                    found = 1'b0;
                    pick  = 0;
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
`ifdef DMEM_CTRL_ROUND_ROBIN_EN
                        idx = (int'(rr_ptr_q) + k) % NUM_CONSUMERS;
`else
                        idx = k;
`endif
                        if (!found && !claim[idx] &&
                            (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
                            found = 1'b1;
                            pick  = idx;
                        end
                    end
                    if (found) begin
                        claim[pick]    = 1'b1;
                        owner_d[ch]    = OWNER_W'(pick);
                        op_write_d[ch] = !consumer_read_valid[pick];
                        wdata_d[ch]    = consumer_write_data[pick];
                        if (consumer_read_valid[pick]) begin
                            state_d[ch] = ST_READ_WAIT;
                            addr_d[ch]  = consumer_read_address[pick];
                        end else begin
                            state_d[ch] = ST_WRITE_WAIT;
                            addr_d[ch]  = consumer_write_address[pick];
                        end
`ifdef DMEM_CTRL_ROUND_ROBIN_EN
                        any_grant = 1'b1;
                        if (pick > hi_grant) hi_grant = pick;
`endif
                    end
                end
                ST_READ_WAIT: begin
                    if (mem_read_ready[ch]) begin
                        state_d[ch]                = ST_RELEASE;
                        rd_data_d[owner_q[ch]]     = mem_read_data[ch];
                        rd_ready_d[owner_q[ch]]    = 1'b1;
                    end
                end
                ST_WRITE_WAIT: begin
                    if (mem_write_ready[ch]) begin
                        state_d[ch]                = ST_RELEASE;
                        wr_ready_d[owner_q[ch]]    = 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (op_write_q[ch]) begin
                        if (!consumer_write_valid[owner_q[ch]]) begin
                            state_d[ch]             = ST_IDLE;
                            wr_ready_d[owner_q[ch]] = 1'b0;
                        end
                    end else if (!consumer_read_valid[owner_q[ch]]) begin
                        state_d[ch]             = ST_IDLE;
                        rd_ready_d[owner_q[ch]] = 1'b0;
                    end
                end
                default: state_d[ch] = ST_IDLE;
            endcase
        end

`ifdef DMEM_CTRL_ROUND_ROBIN_EN
        rd_ptr_update: begin
            rr_ptr_d = any_grant ? OWNER_W'((hi_grant + 1) % NUM_CONSUMERS) : rr_ptr_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= ST_IDLE;
                owner_q[ch] <= '0;
                addr_q[ch]  <= '0;
                wdata_q[ch] <= '0;
            end
            op_write_q <= '0;
            rd_ready_q <= '0;
            wr_ready_q <= '0;
            rd_data_q  <= '0;
`ifdef DMEM_CTRL_ROUND_ROBIN_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= state_d[ch];
                owner_q[ch] <= owner_d[ch];
                addr_q[ch]  <= addr_d[ch];
                wdata_q[ch] <= wdata_d[ch];
            end
            op_write_q <= op_write_d;
            rd_ready_q <= rd_ready_d;
            wr_ready_q <= wr_ready_d;
            rd_data_q  <= rd_data_d;
`ifdef DMEM_CTRL_ROUND_ROBIN_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    generate
        for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan_out
            assign mem_read_valid[ch]    = (state_q[ch] == ST_READ_WAIT);
            assign mem_write_valid[ch]   = (state_q[ch] == ST_WRITE_WAIT);
            assign mem_read_address[ch]  = addr_q[ch];
            assign mem_write_address[ch] = addr_q[ch];
            assign mem_write_data[ch]    = wdata_q[ch];
        end
    endgenerate

    assign consumer_read_ready  = rd_ready_q;
    assign consumer_write_ready = wr_ready_q;
    assign consumer_read_data   = rd_data_q;

endmodule
`default_nettype wire
